bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16, the maximum grant-hold cycles before forced release (only with BUS_ARB_TIMEOUT_EN); legal range 2..255.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset; rst=0 resets immediately, independent of clk.
REQ-004 SHALL have port busreq_1  input  1  bus request from master 1, level-held while the master wants the bus.
REQ-005 SHALL have port busreq_2  input  1  bus request from master 2, level-held.
REQ-006 SHALL have port read_write_1  input  1  master 1 transfer direction (1=read).
REQ-007 SHALL have port read_write_2  input  1  master 2 transfer direction (1=read).
REQ-008 SHALL have port grant_1  output  1  registered bus grant to master 1.
REQ-009 SHALL have port grant_2  output  1  registered bus grant to master 2.
REQ-010 SHALL have port bus_rw  output  1  direction of the current owner; 0 when there is no owner.
REQ-011 SHALL have port bus_busy  output  1  equals grant_1 OR grant_2.
REQ-012 SHALL have port timeout  output  1  one-cycle pulse on forced release.

Function
REQ-013 SHALL implement FSM states IDLE, GNT1, GNT2 and TURN.
REQ-014 SHALL keep grant_1=1 exactly in GNT1 and grant_2=1 exactly in GNT2; the two grants SHALL never be 1 together.
REQ-015 In IDLE or TURN with exactly one request, SHALL enter that master's GNT state at the next edge (one-cycle request-to-grant latency).
REQ-016 With both requests in IDLE or TURN, SHALL grant the master that is not last_owner (round-robin); last_owner SHALL be master 2 after reset, so master 1 wins first.
REQ-017 In IDLE or TURN with no requests, SHALL go to IDLE.
REQ-018 In GNTx, SHALL stay while busreq_x=1; on busreq_x=0 SHALL go to TURN and set last_owner=x.
REQ-019 TURN SHALL last exactly one cycle with both grants 0 (bus turnaround).
REQ-020 SHALL drive bus_rw from read_write_1 in GNT1 and from read_write_2 in GNT2, combinationally from the selected input; bus_rw=0 otherwise.
REQ-021 SHALL use an 8-bit hold counter that clears on entry to GNTx and increments each cycle in GNTx, saturating at 255.
REQ-022 A request from the non-owner SHALL NOT preempt the owner unless BUS_ARB_TIMEOUT_EN is defined.

Reset
REQ-023 While rst=0, SHALL hold state=IDLE, last_owner=2, counter=0, and grant_1, grant_2, bus_rw, bus_busy and timeout all 0.
REQ-024 Reset asserted mid-grant SHALL drop grants asynchronously; after rst returns to 1, the first grant SHALL come no earlier than the first clk edge that samples a request.

Configuration
REQ-025 Macro BUS_ARB_TIMEOUT_EN defined: in GNTx, when counter=MAX_HOLD-1 and the other master requests, SHALL go to TURN, set last_owner=x and pulse timeout for that same cycle in TURN; if the other master does not request, SHALL continue the grant.
REQ-026 Macro undefined: SHALL have no preemption; timeout SHALL be tied to 0; the counter MAY be removed.

Structure
REQ-027 Package bus_arb_pkg SHALL hold the state encoding (IDLE=2'b00, GNT1=2'b01, GNT2=2'b10, TURN=2'b11), the owner encoding and the MAX_HOLD default.
REQ-028 The hold counter and compare logic SHALL be in sub-module arb_hold_timer (inputs clr, en; output expired).

Verification
REQ-029 busreq_1=1 alone from IDLE -> grant_1=1 one edge later; bus_rw follows read_write_1=1 -> bus_rw=1.
REQ-030 busreq_1 and busreq_2 both rise in the same cycle after reset -> grant_1 first; master 1 drops its request -> one TURN cycle with both grants 0, then grant_2=1.
REQ-031 Both masters requesting continuously and each releasing after 3 cycles -> grants alternate 1,2,1,2 with exactly one idle TURN cycle between grants.
REQ-032 With BUS_ARB_TIMEOUT_EN and MAX_HOLD=4: master 1 holds its request, master 2 requests -> grant_1 high for 4 cycles, then timeout=1 for one cycle, then grant_2=1; without the macro -> grant_1 remains high and timeout=0.
REQ-033 rst pulled to 0 during GNT2 between clock edges -> grant_2 falls before the next edge; after release with busreq_2=1 -> grant_2 returns one edge later.
REQ-034 Every test SHALL assert that grant_1 and grant_2 are never 1 together and that bus_busy equals grant_1 OR grant_2 on every cycle.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared state/owner encodings and the default hold limit for bus_arbiter.
package bus_arb_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT1 = 2'b01,
    GNT2 = 2'b10,
    TURN = 2'b11
  } state_t;
  typedef enum logic {
    OWN1 = 1'b0,
    OWN2 = 1'b1
  } owner_t;
  localparam int MAX_HOLD_DEF = 16;
endpackage

// File: rtl/arb_hold_timer.sv
// arb_hold_timer: saturating 8-bit grant-hold counter that flags the last allowed hold cycle.
import bus_arb_pkg::*;
module arb_hold_timer #(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [7:0] cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && cnt != 8'hff) cnt <= cnt + 8'd1;
  end
  assign expired = cnt == 8'(MAX_HOLD - 1);
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin bus arbiter with a one-cycle turnaround between owners.
// Define BUS_ARB_TIMEOUT_EN to force release after MAX_HOLD cycles when the other master waits.
import bus_arb_pkg::*;
module bus_arbiter #(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic busreq_1,
  input  logic busreq_2,
  input  logic read_write_1,
  input  logic read_write_2,
  output logic grant_1,
  output logic grant_2,
  output logic bus_rw,
  output logic bus_busy,
  output logic timeout
);
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("MAX_HOLD must be within 2..255");
  end
  state_t state, nxt;
  owner_t last, nxt_last;
  logic   expired, force_rel, in_gnt;
  assign in_gnt = state == GNT1 || state == GNT2;
`ifdef BUS_ARB_TIMEOUT_EN
  arb_hold_timer #(.MAX_HOLD(MAX_HOLD)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (!in_gnt),
    .en     (in_gnt),
    .expired(expired)
  );
`else
  assign expired = 1'b0;
`endif
  always_comb begin
    nxt       = state;
    nxt_last  = last;
    force_rel = 1'b0;
    case (state)
      GNT1: begin
        force_rel = busreq_1 && busreq_2 && expired;
        if (!busreq_1 || force_rel) begin
          nxt      = TURN;
          nxt_last = OWN1;
        end
      end
      GNT2: begin
        force_rel = busreq_2 && busreq_1 && expired;
        if (!busreq_2 || force_rel) begin
          nxt      = TURN;
          nxt_last = OWN2;
        end
      end
      default: begin
        // IDLE and TURN: on a tie the master that did not own the bus last wins
        if (busreq_1 && busreq_2) nxt = (last == OWN2) ? GNT1 : GNT2;
        else if (busreq_1) nxt = GNT1;
        else if (busreq_2) nxt = GNT2;
        else nxt = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      last    <= OWN2;
      grant_1 <= 1'b0;
      grant_2 <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= nxt;
      last    <= nxt_last;
      grant_1 <= nxt == GNT1;
      grant_2 <= nxt == GNT2;
      timeout <= force_rel;
    end
  end
  assign bus_rw   = grant_1 ? read_write_1 : grant_2 ? read_write_2 : 1'b0;
  assign bus_busy = grant_1 | grant_2;
endmodule
